// File: rtl/pulse_decoder_pkg.sv
// Shared types and helpers for the burst-length pulse decoder.
package pulse_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    WAIT_LOW
  } state_t;

  localparam int MAX_COUNT = 9;
  localparam int CODE_W    = 9;

  // Pulse counter saturates one past the largest legal burst to flag overflow.
  localparam logic [3:0] CNT_SAT = 4'(MAX_COUNT + 1);

  // Length N maps to bit (CODE_W - N): 1 -> MSB, 9 -> LSB; anything else -> 0.
  function automatic logic [CODE_W-1:0] num_to_code(input logic [3:0] n);
    logic [CODE_W-1:0] c;
    c = '0;
    if (n >= 4'd1 && n <= 4'(MAX_COUNT)) begin
      c = 9'h100 >> (n - 4'd1);
    end
    return c;
  endfunction

endpackage

// File: rtl/pulse_decoder_sync.sv
// Two-flop synchronizer for the pulse line with rise/fall strobes on the synchronized level.
module pulse_decoder_sync (
  input  logic clk,
  input  logic _rst,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Flops clear to "high" so a line already high at reset release is not
  // mistaken for a rising edge; a low line then only produces a harmless fall.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;
  assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/pulse_decoder.sv
// Recovers burst length 1..9 from a pulse train; optional short-pulse rejection
// is enabled by defining PULSE_DECODER_GLITCH_FILTER_EN.
module pulse_decoder
  import pulse_decoder_pkg::*;
#(
  parameter int DIV      = 10000000,
  parameter int GAP      = 3,
  parameter int MAX_HIGH = 4,
  parameter int MIN_HIGH = 1
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              in,
  output logic [3:0]        num,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              err,
  output logic              busy
);

  localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HT_MAX = (MAX_HIGH > MIN_HIGH) ? MAX_HIGH : MIN_HIGH;
  localparam int HW     = $clog2(HT_MAX + 1);
  localparam int GW     = $clog2(GAP + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [HW-1:0] MAX_V    = HW'(MAX_HIGH);
  localparam logic [GW-1:0] GAP_V    = GW'(GAP);

  logic level;
  logic rise;
  logic fall;

  pulse_decoder_sync u_sync (
    .clk  (clk),
    ._rst (_rst),
    .in   (in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  logic [PW-1:0] pre_reg;
  logic          tick;

  assign tick = (pre_reg == PRE_LAST);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= tick ? '0 : pre_reg + 1'b1;
    end
  end

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic [HW-1:0]     hticks_reg;
  logic [GW-1:0]     gticks_reg;
  logic [3:0]        num_reg;
  logic [CODE_W-1:0] code_reg;
  logic              valid_reg;
  logic              err_reg;

  logic [3:0]    cnt_inc;
  logic [HW-1:0] hticks_inc;
  logic [GW-1:0] gticks_inc;

  assign cnt_inc    = (cnt_reg == CNT_SAT) ? CNT_SAT : cnt_reg + 4'd1;
  assign hticks_inc = (hticks_reg == '1) ? hticks_reg : hticks_reg + 1'b1;
  assign gticks_inc = (gticks_reg == '1) ? gticks_reg : gticks_reg + 1'b1;

`ifdef PULSE_DECODER_GLITCH_FILTER_EN
  localparam logic [HW-1:0] MIN_V = HW'(MIN_HIGH);
  // Credit a tick landing on the falling edge so a full-width pulse is never
  // rejected purely because of tick phase.
  logic [HW-1:0] hticks_eff;
  logic          pulse_ok;
  assign hticks_eff = tick ? hticks_inc : hticks_reg;
  assign pulse_ok   = (hticks_eff >= MIN_V);
`endif

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hticks_reg <= '0;
      gticks_reg <= '0;
      num_reg    <= '0;
      code_reg   <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_reg  <= HIGH;
            cnt_reg    <= '0;
            hticks_reg <= '0;
          end
        end
        HIGH: begin
          // A fall beats a simultaneous MAX_HIGH tick.
          if (fall) begin
`ifdef PULSE_DECODER_GLITCH_FILTER_EN
            if (pulse_ok) begin
              cnt_reg    <= cnt_inc;
              state_reg  <= LOW;
              gticks_reg <= '0;
            end else if (cnt_reg == 4'd0) begin
              state_reg <= IDLE;
            end else begin
              state_reg  <= LOW;
              gticks_reg <= '0;
            end
`else
            cnt_reg    <= cnt_inc;
            state_reg  <= LOW;
            gticks_reg <= '0;
`endif
          end else if (tick) begin
            hticks_reg <= hticks_inc;
            if (hticks_inc >= MAX_V) begin
              err_reg   <= 1'b1;
              state_reg <= WAIT_LOW;
            end
          end
        end
        LOW: begin
          // Gap termination wins over a coincident rise; that rise is dropped.
          if (tick && (gticks_inc >= GAP_V)) begin
            if (cnt_reg <= 4'(MAX_COUNT)) begin
              num_reg   <= cnt_reg;
              code_reg  <= num_to_code(cnt_reg);
              valid_reg <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end else begin
            if (tick) begin
              gticks_reg <= gticks_inc;
            end
            if (rise) begin
              state_reg  <= HIGH;
              hticks_reg <= '0;
            end
          end
        end
        WAIT_LOW: begin
          if (!level) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign num   = num_reg;
  assign code  = code_reg;
  assign valid = valid_reg;
  assign err   = err_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_pulse_decoder.sv
// Randomized and directed bench for pulse_decoder with a burst-level scoreboard.
module tb_pulse_decoder;

  localparam int DIV      = 4;
  localparam int GAP      = 3;
  localparam int MAX_HIGH = 4;
  localparam int MIN_HIGH = 2;

`ifdef PULSE_DECODER_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_line = 1'b0;
  logic [3:0] num;
  logic [8:0] code;
  logic       valid;
  logic       err;
  logic       busy;

  pulse_decoder #(
    .DIV     (DIV),
    .GAP     (GAP),
    .MAX_HIGH(MAX_HIGH),
    .MIN_HIGH(MIN_HIGH)
  ) dut (
    .clk  (clk),
    ._rst (rst_n),
    .in   (in_line),
    .num  (num),
    .code (code),
    .valid(valid),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int n;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   held_num  = 0;
  int   valid_cnt = 0;
  int   err_cnt   = 0;
  time  err_time  = 0;

  function automatic logic [8:0] onehot(input int n);
    if (n < 1 || n > 9) return 9'd0;
    return 9'b1 << (9 - n);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: strobes must match the scoreboard, outputs must hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        check("valid_allowed", int'(valid),
              (exp_q.size() > 0 && !exp_q[0].is_err) ? 1 : 0);
        if (exp_q.size() > 0 && !exp_q[0].is_err) begin
          check("valid_busy", int'(busy), int'(exp_q[0].busy));
          held_num = exp_q[0].n;
          void'(exp_q.pop_front());
          valid_cnt++;
        end
      end
      if (err) begin
        check("err_allowed", int'(err),
              (exp_q.size() > 0 && exp_q[0].is_err) ? 1 : 0);
        if (exp_q.size() > 0 && exp_q[0].is_err) begin
          check("err_busy", int'(busy), int'(exp_q[0].busy));
          void'(exp_q.pop_front());
          err_cnt++;
          err_time = $time;
        end
      end
      check("valid_err_excl", int'(valid & err), 0);
      check("num_hold", int'(num), held_num);
      check("code_hold", int'(code), int'(onehot(held_num)));
    end
  end

  task automatic seg(input logic v, input int n);
    in_line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  // Burst outcome from the counting rule: pulses (plus a glitch when unfiltered), >9 overflows.
  task automatic send_burst(input int pulses, input int glitch_at, input bit randw);
    exp_t e;
    int   total;
    total = pulses + ((glitch_at >= 0 && !FILT) ? 1 : 0);
    e.is_err = (total > 9);
    e.n      = (total > 9) ? 0 : total;
    e.busy   = 1'b0;
    exp_q.push_back(e);
    for (int p = 0; p < pulses; p++) begin
      seg(1'b1, randw ? int'($urandom_range(10, FILT ? 8 : 5)) : 8);
      if (p < pulses - 1) begin
        if (p == glitch_at) begin
          seg(1'b0, 4);
          seg(1'b1, 1);
          seg(1'b0, 4);
        end else begin
          seg(1'b0, randw ? int'($urandom_range(8, 4)) : 8);
        end
      end
    end
    seg(1'b0, 24);
    drain("burst");
  endtask

  task automatic stuck(input int hi_len);
    exp_t e;
    time  t0;
    e.is_err = 1'b1;
    e.n      = 0;
    e.busy   = 1'b1;
    exp_q.push_back(e);
    t0 = $time;
    seg(1'b1, hi_len);
    check("stuck_err_seen", exp_q.size(), 0);
    check("stuck_err_window",
          ((err_time >= t0 + 140) && (err_time <= t0 + 220)) ? 1 : 0, 1);
    check("stuck_busy_high", int'(busy), 1);
    seg(1'b0, 12);
    drain("stuck_release");
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int e0;
    int np;
    int ga;

    repeat (3) @(negedge clk);
    check("rst_num", int'(num), 0);
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    seg(1'b0, 10);

    send_burst(3, -1, 1'b0);
    $display("burst 3 -> num=%0d code=%b", num, code);
    check("t1_num", int'(num), 3);
    check("t1_code", int'(code), 9'b001000000);

    v0 = valid_cnt;
    send_burst(1, -1, 1'b0);
    $display("burst 1 -> num=%0d code=%b", num, code);
    check("t2_num1", int'(num), 1);
    check("t2_code1", int'(code), 9'b100000000);
    send_burst(9, -1, 1'b0);
    $display("burst 9 -> num=%0d code=%b", num, code);
    check("t2_num9", int'(num), 9);
    check("t2_code9", int'(code), 9'b000000001);
    check("t2_valid_count", valid_cnt - v0, 2);

    v0 = valid_cnt;
    e0 = err_cnt;
    send_burst(10, -1, 1'b0);
    $display("burst 10 -> err_count=%0d num=%0d", err_cnt - e0, num);
    check("t3_err_count", err_cnt - e0, 1);
    check("t3_valid_count", valid_cnt - v0, 0);
    check("t3_num_kept", int'(num), 9);

    stuck(40);
    $display("stuck high 40 clk -> err at %0t", err_time);
    send_burst(2, -1, 1'b0);
    check("t4_num", int'(num), 2);

    seg(1'b1, 8); seg(1'b0, 8); seg(1'b1, 8); seg(1'b0, 8); seg(1'b1, 4);
    #2;
    rst_n = 1'b0;
    held_num = 0;
    exp_q.delete();
    #1;
    $display("reset mid-burst -> num=%0d code=%b busy=%0d", num, code, busy);
    check("t5_num", int'(num), 0);
    check("t5_code", int'(code), 0);
    check("t5_valid", int'(valid), 0);
    check("t5_err", int'(err), 0);
    check("t5_busy", int'(busy), 0);
    in_line = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seg(1'b0, 10);
    send_burst(4, -1, 1'b0);
    check("t5_num4", int'(num), 4);

    v0 = valid_cnt;
    e0 = err_cnt;
    in_line = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    held_num = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seg(1'b1, 20);
    check("hi_release_busy", int'(busy), 0);
    seg(1'b0, 24);
    $display("line high at release -> strobes=%0d", (valid_cnt - v0) + (err_cnt - e0));
    check("hi_release_strobes", (valid_cnt - v0) + (err_cnt - e0), 0);

    send_burst(2, 0, 1'b0);
    $display("glitch burst -> num=%0d", num);
    check("t6_glitch_num", int'(num), FILT ? 2 : 3);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(9, 0) == 0) begin
        stuck(int'($urandom_range(40, 30)));
        $display("rand %0d: stuck -> err", i);
      end else begin
        np = int'($urandom_range(11, 1));
        ga = (np >= 2 && $urandom_range(3, 0) == 0) ? int'($urandom_range(np - 2, 0)) : -1;
        send_burst(np, ga, 1'b1);
        $display("rand %0d: pulses=%0d glitch_at=%0d -> num=%0d", i, np, ga, num);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
